gf_mod_reduce_seq: RTL and testbench



---
 rtl/gf_mod_reduce_seq.sv | 116 +++++++++++
 tb/tb_gf_mod_reduce_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mod_reduce_seq.sv
// gf_mod_reduce_seq: bit-serial reduction of a carry-less product modulo
// a programmable degree-DATA_WIDTH polynomial over GF(2).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for prod/poly
//   prod [2W-1:0]       carry-less product, bit i = coefficient of x^i
//   poly [W-1:0]        x^0..x^(W-1) of the modulus, x^W term implicit
//   out_valid/out_ready output handshake for rem
//   rem  [W-1:0]        prod mod {1,poly}
//   busy                operation in flight (RUN or DONE)
module gf_mod_reduce_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] prod,
    input  logic [DATA_WIDTH-1:0]   poly,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   rem,
    output logic                    busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state, state_d;
    logic [PW-1:0]   w, w_d;
    logic [DATA_WIDTH-1:0] p, p_d;
    logic [CW-1:0]   cnt, cnt_d;

    logic [DATA_WIDTH-1:0] hi;
    logic                  lead;
    logic [PW-1:0]         step;
    logic                  accept;

    // Leading coefficient under test is x^(DATA_WIDTH+cnt).
    assign hi   = w[PW-1:DATA_WIDTH];
    assign lead = hi[cnt];
    // {1,p} aligned so its implicit x^DATA_WIDTH term cancels the lead.
    assign step = {{(DATA_WIDTH-1){1'b0}}, 1'b1, p} << cnt;

    assign in_ready  = (state == IDLE) |
                       ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) | (state == DONE);
    assign rem       = w[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            w     <= '0;
            p     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            w     <= w_d;
            p     <= p_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        w_d     = w;
        p_d     = p;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    w_d     = prod;
                    p_d     = poly;
                    cnt_d   = CW'(DATA_WIDTH - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (lead) begin
                    w_d = w ^ step;
                end
                if (cnt == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            DONE: begin
                // Handoff: a new operand may be taken on the same edge
                // that the current result is consumed.
                if (out_ready) begin
                    state_d = IDLE;
                    if (accept) begin
                        w_d     = prod;
                        p_d     = poly;
                        cnt_d   = CW'(DATA_WIDTH - 1);
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gf_mod_reduce_seq.sv
// tb_gf_mod_reduce_seq: directed vectors at DATA_WIDTH=8 plus randomized
// checks at DATA_WIDTH=32 against a Horner-form polynomial model.
module tb_gf_mod_reduce_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] prod;
    logic [7:0]  poly;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  rem;
    logic        busy;

    logic        in_valid32;
    logic        in_ready32;
    logic [63:0] prod32;
    logic [31:0] poly32;
    logic        out_valid32;
    logic        out_ready32;
    logic [31:0] rem32;
    logic        busy32;

    int n_run;
    int n_fail;

    gf_mod_reduce_seq #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .poly      (poly),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rem       (rem),
        .busy      (busy)
    );

    gf_mod_reduce_seq #(.DATA_WIDTH(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .prod      (prod32),
        .poly      (poly32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .rem       (rem32),
        .busy      (busy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        logic [7:0]  poly;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // r = r*x + bit with x^32 folded back as poly.
    function automatic logic [31:0] ref32(input logic [63:0] pr,
                                          input logic [31:0] po);
        logic [31:0] r;
        logic        ov;
        r = '0;
        for (int i = 63; i >= 0; i--) begin
            ov = r[31];
            r  = {r[30:0], pr[i]};
            if (ov) r = r ^ po;
        end
        return r;
    endfunction

    // Accept one operand, then count edges until out_valid.
    task automatic op8(input logic [15:0] pr, input logic [7:0] po,
                       output logic [7:0] r, output int lat,
                       output logic bz);
        @(negedge clk);
        in_valid = 1'b1;
        prod     = pr;
        poly     = po;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        prod     = ~pr;
        poly     = ~po;
        lat = 0;
        bz  = 1'b1;
        while (!out_valid && lat < 100) begin
            if (!busy) bz = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!busy) bz = 1'b0;
        r = rem;
    endtask

    logic [7:0]  r8;
    logic [31:0] e32;
    logic [63:0] rp;
    logic [31:0] rq;
    int          lat;
    int          gap;
    logic        bz;
    logic        seen;

    initial begin
        n_run       = 0;
        n_fail      = 0;
        in_valid    = 1'b0;
        prod        = '0;
        poly        = '0;
        out_ready   = 1'b1;
        in_valid32  = 1'b0;
        prod32      = '0;
        poly32      = '0;
        out_ready32 = 1'b1;

        vt[0] = '{16'h2B79, 8'h1B, 8'hC1};
        vt[1] = '{16'h0100, 8'h1B, 8'h1B};
        vt[2] = '{16'h0053, 8'h1B, 8'h53};
        vt[3] = '{16'h1234, 8'h00, 8'h34};
        vt[4] = '{16'h8000, 8'h1B, 8'h2F};
        vt[5] = '{16'h00FF, 8'h1B, 8'hFF};

        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rem", rem, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            op8(vt[i].prod, vt[i].poly, r8, lat, bz);
            chk($sformatf("vec%0d_rem", i), r8, vt[i].exp);
            chk($sformatf("vec%0d_lat", i), lat, 8);
            chk($sformatf("vec%0d_busy", i), bz, 1);
        end
        @(posedge clk);
        #1;
        chk("idle_after_vec", busy, 0);

        // Backpressure with a rejected in_valid while DONE is stalled.
        out_ready = 1'b0;
        op8(16'h2B79, 8'h1B, r8, lat, bz);
        chk("bp_lat", lat, 8);
        in_valid = 1'b1;
        prod     = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_rem", rem, 8'hC1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_busy", busy, 0);
        chk("bp_release_in_ready", in_ready, 1);

        // Back-to-back handoff.
        @(negedge clk);
        in_valid = 1'b1;
        prod     = 16'h0100;
        poly     = 8'h1B;
        @(posedge clk);
        #1;
        prod = 16'h2B79;
        lat  = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_first_lat", lat, 8);
        chk("b2b_first_rem", rem, 8'h1B);
        chk("b2b_handoff_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_reaccept_busy", busy, 1);
        gap = 1;
        while (!out_valid && gap < 100) begin
            @(posedge clk);
            #1;
            gap++;
        end
        chk("b2b_gap", gap, 9);
        chk("b2b_second_rem", rem, 8'hC1);
        @(posedge clk);
        #1;
        chk("b2b_idle", busy, 0);

        // Reset during the 4th RUN cycle.
        @(negedge clk);
        in_valid = 1'b1;
        prod     = 16'h2B79;
        poly     = 8'h1B;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rem", rem, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 0);
        op8(16'h0100, 8'h1B, r8, lat, bz);
        chk("abort_after_rem", r8, 8'h1B);
        chk("abort_after_lat", lat, 8);

        // DATA_WIDTH=32 randomized.
        for (int k = 0; k < 1000; k++) begin
            rp = {$urandom, $urandom};
            rq = $urandom;
            if (k == 0) rq = '0;
            e32 = ref32(rp, rq);
            @(negedge clk);
            in_valid32 = 1'b1;
            prod32     = rp;
            poly32     = rq;
            @(posedge clk);
            #1;
            in_valid32 = 1'b0;
            prod32     = ~rp;
            poly32     = ~rq;
            lat = 0;
            while (!out_valid32 && lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("w32_%0d_rem", k), rem32, e32);
            chk($sformatf("w32_%0d_lat", k), lat, 32);
            chk($sformatf("w32_%0d_hi", k), dut32.w[63:32], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
